// File: rtl/note_video_pkg.sv
// Shared video constants, sprite slot record and the fixed colour-index-to-RGB map.
package note_video_pkg;

    localparam int H_ACTIVE   = 1024;
    localparam int V_ACTIVE   = 768;
    localparam int COLOR_BITS = 8;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
    } slot_t;

    // Red follows the index, green is its complement, blue is the nibble-swapped index.
    function automatic logic [23:0] palette_rgb(input logic [COLOR_BITS-1:0] idx);
        return {idx, ~idx, idx[3:0], idx[7:4]};
    endfunction

endpackage

// File: rtl/note_sprite_layer_if.sv
// Video timing, slot-load bus, bitmap ROM port and pixel output of the sprite layer.
interface note_sprite_layer_if #(
    parameter int ADDR_BITS = 11
);
    logic [10:0]          hcount;
    logic [9:0]           vcount;
    logic                 frame_start;
    logic                 load;
    logic [3:0]           load_idx;
    logic [10:0]          load_x;
    logic [9:0]           load_y;
    logic                 load_en;
    logic [3:0]           scroll_step;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [7:0]           rom_data;
    logic [23:0]          pixel_out;
    logic                 pixel_opaque;

    modport master (
        output hcount, vcount, frame_start, load, load_idx, load_x, load_y, load_en,
               scroll_step, rom_data,
        input  rom_addr, pixel_out, pixel_opaque
    );

    modport slave (
        input  hcount, vcount, frame_start, load, load_idx, load_x, load_y, load_en,
               scroll_step, rom_data,
        output rom_addr, pixel_out, pixel_opaque
    );
endinterface

// File: rtl/note_palette.sv
// Synchronous 256 x 24 colour lookup, one cycle latency, no reset on the data path.
module note_palette
    import note_video_pkg::*;
(
    input  logic                  clk,
    input  logic [COLOR_BITS-1:0] idx,
    output logic [23:0]           rgb
);

    logic [23:0] rgb_table [256];
    logic [23:0] rgb_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_entry
            assign rgb_table[gi] = palette_rgb(8'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        rgb_reg <= rgb_table[idx];
    end

    assign rgb = rgb_reg;

endmodule

// File: rtl/note_sprite_layer.sv
// Multi-slot sprite renderer with per-frame scrolling and a 3-cycle pixel pipeline.
// Optional: define SPRITE_WRAP_EN to restart off-screen sprites at y=0 instead of disabling them.
module note_sprite_layer
    import note_video_pkg::*;
#(
    parameter int WIDTH             = 64,
    parameter int HEIGHT            = 32,
    parameter int NUM_SPRITES       = 4,
    parameter int ADDR_BITS         = 11,
    parameter int V_LIMIT           = 768,
    parameter int TRANSPARENT_INDEX = 0
) (
    input  logic                pixel_clk,
    input  logic                reset,
    note_sprite_layer_if.slave  bus
);

    localparam logic [10:0] V_LIMIT_W = 11'(V_LIMIT);

    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic [NUM_SPRITES-1:0] hit;
    logic [11:0] dx [NUM_SPRITES];
    logic [11:0] dy [NUM_SPRITES];

    assign h_ext = {1'b0, bus.hcount};
    assign v_ext = {2'b0, bus.vcount};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
            slot_t       slot_reg;
            slot_t       slot_next;
            logic [10:0] y_sum;
            logic [11:0] x_lo;
            logic [11:0] y_lo;

            // A load to this slot takes precedence over a simultaneous scroll.
            always_comb begin
                y_sum     = {1'b0, slot_reg.y} + {7'b0, bus.scroll_step};
                slot_next = slot_reg;
                if (bus.load && (bus.load_idx == 4'(gi))) begin
                    slot_next.x  = bus.load_x;
                    slot_next.y  = bus.load_y;
                    slot_next.en = bus.load_en;
                end else if (bus.frame_start && slot_reg.en) begin
                    if (y_sum[10] || (y_sum >= V_LIMIT_W)) begin
`ifdef SPRITE_WRAP_EN
                        slot_next.y = '0;
`else
                        slot_next.en = 1'b0;
`endif
                    end else begin
                        slot_next.y = y_sum[9:0];
                    end
                end
            end

            always_ff @(posedge pixel_clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            // 12-bit bounds so sprites near the right/bottom edge never wrap to the origin.
            assign x_lo    = {1'b0, slot_reg.x};
            assign y_lo    = {2'b0, slot_reg.y};
            assign hit[gi] = slot_reg.en
                          && (h_ext >= x_lo) && (h_ext < x_lo + 12'(WIDTH))
                          && (v_ext >= y_lo) && (v_ext < y_lo + 12'(HEIGHT));
            assign dx[gi]  = h_ext - x_lo;
            assign dy[gi]  = v_ext - y_lo;
        end
    endgenerate

    logic                 any_hit;
    logic [11:0]          win_dx;
    logic [11:0]          win_dy;
    logic [ADDR_BITS-1:0] rom_addr_next;

    // Scan from the highest index down so the lowest hitting index ends up selected.
    always_comb begin
        any_hit = 1'b0;
        win_dx  = '0;
        win_dy  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                win_dx  = dx[i];
                win_dy  = dy[i];
            end
        end
        rom_addr_next = ADDR_BITS'(win_dx) + ADDR_BITS'(win_dy) * ADDR_BITS'(WIDTH);
    end

    logic [ADDR_BITS-1:0] rom_addr_reg;
    logic                 hit_d1_reg;
    logic                 hit_d2_reg;
    logic                 opaque_reg;
    logic [23:0]          pal_rgb;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rom_addr_reg <= '0;
            hit_d1_reg   <= 1'b0;
            hit_d2_reg   <= 1'b0;
            opaque_reg   <= 1'b0;
        end else begin
            rom_addr_reg <= rom_addr_next;
            hit_d1_reg   <= any_hit;
            hit_d2_reg   <= hit_d1_reg;
            opaque_reg   <= hit_d2_reg && (bus.rom_data != 8'(TRANSPARENT_INDEX));
        end
    end

    note_palette u_palette (
        .clk (pixel_clk),
        .idx (bus.rom_data),
        .rgb (pal_rgb)
    );

    // The palette register has no reset, so the opaque flag gates its output.
    assign bus.rom_addr     = rom_addr_reg;
    assign bus.pixel_out    = opaque_reg ? pal_rgb : 24'h0;
    assign bus.pixel_opaque = opaque_reg;

endmodule

// File: tb/tb_note_sprite_layer.sv
// Self-checking bench for note_sprite_layer: a frame-level model plus directed probes.
module tb_note_sprite_layer;

    localparam int NS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic checking = 1'b0;
    int   rom_mode = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    note_sprite_layer_if #(.ADDR_BITS(11)) bus ();

    note_sprite_layer dut (
        .pixel_clk (clk),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct packed { int x; int y; bit en; } mslot_t;
    typedef struct packed { bit op; logic [23:0] pix; logic [31:0] addr; } exp_t;

    mslot_t ms [NS];
    exp_t   hist [3];

    function automatic logic [23:0] pal(int idx);
        int r = idx;
        int g = 255 - idx;
        int b = (idx % 16) * 16 + idx / 16;
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    function automatic int rom_fn(int addr);
        case (rom_mode)
            0:       return 5;
            1:       return ((addr / 64 >= 16) && (addr % 64 >= 32)) ? 0 : 5;
            default: return addr % 256;
        endcase
    endfunction

    // Expected output for a screen position: first enabled sprite covering it, no fall-through.
    function automatic exp_t model_pixel(int h, int v);
        exp_t e = '0;
        int idx;
        for (int i = 0; i < NS; i++) begin
            if (ms[i].en && h >= ms[i].x && h < ms[i].x + 64 && v >= ms[i].y && v < ms[i].y + 32) begin
                e.addr = 32'((h - ms[i].x) + (v - ms[i].y) * 64);
                idx    = rom_fn(int'(e.addr));
                e.op   = (idx != 0);
                e.pix  = e.op ? pal(idx) : 24'h0;
                return e;
            end
        end
        return e;
    endfunction

    function automatic mslot_t next_slot(int i, mslot_t s);
        mslot_t n = s;
        int ny;
        if (reset) return '0;
        if (bus.load && int'(bus.load_idx) == i) begin
            n.x  = int'(bus.load_x);
            n.y  = int'(bus.load_y);
            n.en = bus.load_en;
        end else if (bus.frame_start && s.en) begin
            ny = s.y + int'(bus.scroll_step);
            if (ny >= 768) begin
`ifdef SPRITE_WRAP_EN
                n.y = 0;
`else
                n.en = 1'b0;
`endif
            end else begin
                n.y = ny;
            end
        end
        return n;
    endfunction

    // ROM with one cycle of read latency.
    always @(posedge clk) bus.rom_data <= 8'(rom_fn(int'(bus.rom_addr)));

    // Model: slot state and a 3-deep latency history of expected outputs.
    always @(posedge clk) begin
        if (reset) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else begin
            hist[0] <= model_pixel(int'(bus.hcount), int'(bus.vcount));
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
        for (int i = 0; i < NS; i++) ms[i] <= next_slot(i, ms[i]);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("rom_addr", 32'(bus.rom_addr), hist[0].addr);
            chk("pixel_out", 32'(bus.pixel_out), 32'(hist[2].pix));
            chk("pixel_opaque", 32'(bus.pixel_opaque), 32'(hist[2].op));
        end
    end

    task automatic set_pos(int h, int v);
        @(negedge clk);
        bus.hcount      = 11'(h);
        bus.vcount      = 10'(v);
        bus.load        = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) set_pos(1100, 900);
    endtask

    task automatic do_load(int idx, int x, int y, bit en, bit fs);
        @(negedge clk);
        bus.load        = 1'b1;
        bus.load_idx    = 4'(idx);
        bus.load_x      = 11'(x);
        bus.load_y      = 10'(y);
        bus.load_en     = en;
        bus.frame_start = fs;
        $display("load slot=%0d x=%0d y=%0d en=%0d frame_start=%0d", idx, x, y, en, fs);
        idle(2);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.load        = 1'b0;
        bus.frame_start = 1'b1;
        $display("frame_start step=%0d", bus.scroll_step);
        idle(2);
    endtask

    task automatic probe(string name, int h, int v, int exp_addr, bit exp_op, logic [23:0] exp_pix);
        set_pos(h, v);
        @(negedge clk);
        chk({name, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
        @(negedge clk);
        @(negedge clk);
        chk({name, "_opaque"}, 32'(bus.pixel_opaque), 32'(exp_op));
        chk({name, "_pix"}, 32'(bus.pixel_out), 32'(exp_pix));
        $display("probe %s h=%0d v=%0d addr=%0d opaque=%0d pix=%06h", name, h, v,
                 bus.rom_addr, bus.pixel_opaque, bus.pixel_out);
    endtask

    initial begin
        logic seen_op;
        bus.hcount = '0; bus.vcount = '0; bus.frame_start = 1'b0; bus.load = 1'b0;
        bus.load_idx = '0; bus.load_x = '0; bus.load_y = '0; bus.load_en = 1'b0;
        bus.scroll_step = '0;

        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("reset_pixel_out", 32'(bus.pixel_out), 32'd0);
        chk("reset_opaque", 32'(bus.pixel_opaque), 32'd0);
        chk("palette_model_5", 32'(pal(5)), 32'h05FA50);
        @(negedge clk);
        reset = 1'b0;

        // Coarse frame sweep with nothing loaded.
        seen_op = 1'b0;
        for (int v = 0; v < 768; v += 48)
            for (int h = 0; h < 1024; h += 32) begin
                set_pos(h, v);
                seen_op = seen_op | bus.pixel_opaque;
            end
        idle(3);
        chk("empty_frame_opaque", 32'(seen_op), 32'd0);

        // Single sprite at (100,200).
        do_load(0, 100, 200, 1'b1, 1'b0);
        probe("s0_topleft", 100, 200, 0, 1'b1, 24'h05FA50);
        probe("s0_botright", 163, 231, 2047, 1'b1, 24'h05FA50);
        probe("s0_right_out", 164, 231, 0, 1'b0, 24'h0);
        probe("s0_left_out", 99, 200, 0, 1'b0, 24'h0);
        probe("s0_below_out", 100, 232, 0, 1'b0, 24'h0);
        probe("s0_above_out", 163, 199, 0, 1'b0, 24'h0);
        idle(3);
        rom_mode = 2;
        for (int v = 198; v < 235; v += 3)
            for (int h = 96; h < 170; h += 3) set_pos(h, v);
        idle(4);

        // Overlap: slot0 wins and its transparent quadrant hides slot1.
        rom_mode = 1;
        do_load(0, 300, 300, 1'b1, 1'b0);
        do_load(1, 332, 316, 1'b1, 1'b0);
        probe("ovl_no_fallthrough", 340, 320, 1320, 1'b0, 24'h0);
        probe("ovl_s1_only", 380, 320, 304, 1'b1, 24'h05FA50);
        probe("ovl_s0_opaque", 310, 305, 330, 1'b1, 24'h05FA50);
        probe("ovl_s1_transp", 390, 345, 1914, 1'b0, 24'h0);
        for (int v = 296; v < 352; v += 4)
            for (int h = 296; h < 400; h += 4) set_pos(h, v);
        idle(4);

        // Out-of-range slot index ignored; no wrap at the right edge.
        do_load(7, 700, 100, 1'b1, 1'b0);
        probe("bad_idx_ignored", 700, 100, 0, 1'b0, 24'h0);
        do_load(1, 2000, 400, 1'b1, 1'b0);
        probe("no_hwrap", 5, 400, 0, 1'b0, 24'h0);
        probe("right_edge", 2047, 400, 47, 1'b1, 24'h05FA50);
        do_load(0, 0, 0, 1'b0, 1'b0);
        do_load(1, 0, 0, 1'b0, 1'b0);
        idle(4);

        // Scrolling past V_LIMIT.
        rom_mode = 0;
        bus.scroll_step = 4'd15;
        do_load(2, 500, 740, 1'b1, 1'b0);
        frame_pulse();
        chk("scroll1_model_y", 32'(ms[2].y), 32'd755);
        probe("scroll1_top", 500, 755, 0, 1'b1, 24'h05FA50);
        probe("scroll1_above", 500, 754, 0, 1'b0, 24'h0);
        frame_pulse();
`ifdef SPRITE_WRAP_EN
        chk("scroll2_model_y", 32'(ms[2].y), 32'd0);
        chk("scroll2_model_en", 32'(ms[2].en), 32'd1);
        probe("scroll2_wrapped", 500, 0, 0, 1'b1, 24'h05FA50);
`else
        chk("scroll2_model_y", 32'(ms[2].y), 32'd755);
        chk("scroll2_model_en", 32'(ms[2].en), 32'd0);
        probe("scroll2_disabled", 500, 760, 0, 1'b0, 24'h0);
`endif

        // Load and frame_start together.
        bus.scroll_step = 4'd4;
        do_load(0, 100, 50, 1'b1, 1'b0);
        do_load(3, 600, 10, 1'b1, 1'b1);
        chk("same_cycle_s3_y", 32'(ms[3].y), 32'd10);
        chk("same_cycle_s0_y", 32'(ms[0].y), 32'd54);
        probe("same_s0_top", 100, 54, 0, 1'b1, 24'h05FA50);
        probe("same_s0_above", 100, 53, 0, 1'b0, 24'h0);
        probe("same_s3_top", 600, 10, 0, 1'b1, 24'h05FA50);
        probe("same_s3_above", 600, 9, 0, 1'b0, 24'h0);

        // Reset in the middle of an opaque run.
        for (int h = 90; h < 120; h++) set_pos(h, 60);
        chk("pre_reset_opaque", 32'(bus.pixel_opaque), 32'd1);
        @(negedge clk);
        bus.hcount = 11'd120;
        reset = 1'b1;
        $display("reset asserted mid-line");
        @(negedge clk);
        chk("reset_clears_opaque", 32'(bus.pixel_opaque), 32'd0);
        bus.hcount = 11'd121;
        @(negedge clk);
        reset = 1'b0;
        bus.hcount = 11'd122;
        for (int h = 123; h < 141; h++) set_pos(h, 60);
        chk("post_reset_opaque", 32'(bus.pixel_opaque), 32'd0);
        chk("post_reset_pix", 32'(bus.pixel_out), 32'd0);
        idle(4);

        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
